load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage initiator for the data memory, which is a word-wide responder with a
//  1-cycle registered read. Accepts one load/store request per handshake and
//  drives full-word memory cycles only. Byte/half stores are done as
//  read-modify-write. Load byte lanes are extracted and sign/zero-extended here.
//  req_ready is low while busy; the pipeline uses it as the MEM-stage stall.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width, shared with the data memory
//  DATA_WIDTH  32  data width; only 32 is supported
// PORTS
//  clock          in   1           rising-edge clock
//  reset_n        in   1           asynchronous active-low reset
//  req_valid      in   1           request present
//  req_ready      out  1           high only in IDLE; transfer = req_valid & req_ready
//  req_we         in   1           1 = store, 0 = load
//  req_funct3     in   3           insn[14:12] (size/sign)
//  req_addr       in   ADDR_WIDTH  byte address
//  req_wdata      in   DATA_WIDTH  store data, right-justified
//  rsp_valid      out  1           registered 1-cycle completion pulse
//  rsp_rdata      out  DATA_WIDTH  extended load data; 0 for stores
//  misalign_err   out  1           qualifies rsp_valid; tied 0 unless macro defined
//  mem_read_en    out  1           to memory read_en
//  mem_write_en   out  1           to memory write_en
//  mem_address    out  ADDR_WIDTH  word-aligned address, [1:0]=0
//  mem_data_in    out  DATA_WIDTH  full write word
//  mem_funct3     out  3           constant 3'b010 (word)
//  mem_data_out   in   DATA_WIDTH  memory read data, valid the cycle after mem_read_en
// BEHAVIOUR
//  - Reset: clock and reset_n only; reset is asynchronous, active-low.
//    State=IDLE. rsp_valid, rsp_rdata, misalign_err and captured regs all 0.
//    mem_* enables are decoded from state, so they read 0 immediately.
//  - On accept (edge E0): latch we, funct3, addr, wdata.
//    Next state: sw -> WR; any load or sb/sh -> RD.
//  - FSM states: IDLE, RD, LD_DATA, WR, RMW_WR. req_ready = (state==IDLE).
//  - RD: mem_read_en=1. Next state: load -> LD_DATA; store -> RMW_WR.
//  - LD_DATA: register the extracted result into rsp_rdata, pulse rsp_valid -> IDLE.
//  - Lane extraction:
//    byte = mem_data_out >> 8*addr[1:0]; half = mem_data_out >> 16*addr[1].
//    Extend by funct3: 000 lb sext8, 001 lh sext16, 100 lbu zext8, 101 lhu zext16.
//    010/011/110/111 are full word.
//  - WR: mem_write_en=1, mem_data_in=wdata -> IDLE with rsp_valid pulse.
//  - RMW_WR: mem_write_en=1; mem_data_in = mem_data_out with the addressed
//    byte/half lane replaced by wdata[7:0]/[15:0] -> IDLE with rsp_valid pulse.
//  - Store size: funct3 000=sb, 001=sh, anything else = sw.
//  - Latency (accept at E0, cycle n = after edge En-1):
//    sw: rsp in cycle 2. sb/sh/loads: rsp in cycle 3.
//    req_ready rises in the same cycle as rsp_valid, so back-to-back accept is allowed.
//  - mem_address = {addr[ADDR_WIDTH-1:2],2'b00}. mem_data_in = 0 outside write states.
//  - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//    Without the macro, the address is rounded down to natural alignment.
//  - Reset asserted mid-operation:
//    Enables drop asynchronously; a pending write is not performed; no rsp issued.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN
//  - Defined: a misaligned request is accepted without any mem_* activity.
//    Next cycle: rsp_valid=1, misalign_err=1, rsp_rdata=0. State stays IDLE.
//  - Undefined: misalign_err is constant 0; misaligned requests are rounded down.
// TESTING
//  1 Preload MEM[1]=0x8000F0A5. lb 0x004 -> 0xFFFFFFA5; lbu 0x005 -> 0x000000F0;
//    lh 0x006 -> 0xFFFF8000; lhu 0x006 -> 0x00008000. Each rsp in cycle 3.
//  2 sw 0x010 0xDEADBEEF -> one mem_write_en cycle, rsp cycle 2;
//    lw 0x010 -> 0xDEADBEEF.
//  3 sb 0x011 0x77 -> MEM[4]=0xDEAD77EF, rsp cycle 3;
//    then sh 0x012 0x1234 -> MEM[4]=0x123477EF.
//  4 req_valid held high with two loads -> accepts at E0 and E3;
//    req_ready low cycles 1-2; rsp_valid pulses in cycles 3 and 6.
//  5 reset_n low during RMW_WR -> mem_write_en=0 at once; MEM unchanged;
//    no rsp; req_ready=1 after release.
//  6 lw 0x013 -> macro on: rsp cycle 1, misalign_err=1, no mem_read_en;
//    macro off: returns MEM[4].

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = LSU view, master = pipeline + memory view.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  misalign_err;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, misalign_err,
               mem_read_en, mem_write_en, mem_address, mem_data_in, mem_funct3
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, misalign_err,
               mem_read_en, mem_write_en, mem_address, mem_data_in, mem_funct3
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-only memory cycles, RMW for sb/sh, load lane extend.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests answer with misalign_err, no memory access.
module load_store_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, LD_DATA, WR, RMW_WR} state_t;

    state_t                r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_accept;
    logic                  w_trap;
    logic                  w_req_sw;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge;
    logic [DATA_WIDTH-1:0] w_mem_data_in;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    // stores: only 000/001 are sub-word, every other funct3 is a full word
    assign w_req_sw = bus.req_we && (bus.req_funct3[2:1] != 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_req_half;
    logic w_req_word;
    logic r_misalign_err;

    assign w_req_half = bus.req_we ? (bus.req_funct3 == 3'b001) : (bus.req_funct3[1:0] == 2'b01);
    assign w_req_word = bus.req_we ? w_req_sw : bus.req_funct3[1];
    assign w_trap     = (w_req_half && bus.req_addr[0]) ||
                        (w_req_word && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= w_accept && w_trap;
        end
    end

    assign bus.misalign_err = r_misalign_err;
`else
    assign w_trap           = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    // lane selection ignores the low address bits below natural alignment
    assign w_byte = 8'(bus.mem_data_out >> {r_addr[1:0], 3'b000});
    assign w_half = 16'(bus.mem_data_out >> {r_addr[1], 4'b0000});

    always_comb begin
        w_load_data = bus.mem_data_out;
        case (r_funct3)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_data = bus.mem_data_out;
        endcase
    end

    always_comb begin
        w_merge = bus.mem_data_out;
        if (r_funct3 == 3'b000) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_mem_data_in = '0;
        case (r_state)
            WR:      w_mem_data_in = r_wdata;
            RMW_WR:  w_mem_data_in = w_merge;
            default: w_mem_data_in = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_trap) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_state  <= w_req_sw ? WR : RD;
                    end
                end
                RD: begin
                    r_state <= r_we ? RMW_WR : LD_DATA;
                end
                LD_DATA: begin
                    r_rsp_rdata <= w_load_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                WR, RMW_WR: begin
                    r_rsp_rdata <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // enables come straight from state so an asynchronous reset kills them at once
    assign bus.req_ready    = (r_state == IDLE);
    assign bus.mem_read_en  = (r_state == RD);
    assign bus.mem_write_en = (r_state == WR) || (r_state == RMW_WR);
    assign bus.mem_address  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_data_in  = w_mem_data_in;
    assign bus.mem_funct3   = 3'b010;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic vs. a byte-level memory model.
// Honours LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_load_store_unit;

    logic clock;
    logic reset_n;

    load_store_unit_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // word memory responder with a one-cycle registered read
    logic [31:0] mem [0:1023];
    logic [31:0] mem_q;
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_write_en) mem[bus.mem_address[11:2]] <= bus.mem_data_in;
        if (bus.mem_read_en) mem_q <= mem[bus.mem_address[11:2]];
    end
    assign bus.mem_data_out = mem_q;

    logic [31:0] ref_mem [0:1023];
    int n_total;
    int n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_idx  = 10'(idx);
        pre_data = data;
        ref_mem[idx] = data;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // access size in bytes as the ISA defines it
    function automatic int size_of(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [11:0] addr);
        logic [31:0] w;
        logic [31:0] v;
        int sz;
        w  = ref_mem[addr / 4];
        sz = size_of(1'b0, f3);
        if (sz == 1) begin
            v = (w >> (8 * (addr % 4))) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2) begin
            v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] wdata);
        int sz, exp_lat, exp_rd, exp_wr, got_lat, rd_cnt, wr_cnt, sh;
        logic trap, got_err;
        logic [31:0] exp_data, exp_word, got_data, wr_word, old;
        sz  = size_of(we, f3);
        old = ref_mem[addr / 4];
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`endif
        exp_word = old;
        exp_data = 32'h0;
        if (trap) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            exp_data = exp_load(f3, addr);
        end else begin
            exp_lat = (sz == 4) ? 2 : 3;
            exp_rd  = (sz == 4) ? 0 : 1;
            exp_wr  = 1;
            if (sz == 1) begin
                sh = 8 * (addr % 4);
                exp_word = (old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            end else if (sz == 2) begin
                sh = 16 * ((addr / 2) % 2);
                exp_word = (old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            end else begin
                exp_word = wdata;
            end
            ref_mem[addr / 4] = exp_word;
        end

        @(negedge clock);
        check_eq("ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        got_lat = 0; rd_cnt = 0; wr_cnt = 0;
        got_data = 32'h0; got_err = 1'b0; wr_word = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            if (bus.mem_read_en) begin
                rd_cnt++;
                check_eq("rd_addr", 32'(bus.mem_address), 32'(addr & 12'hFFC));
            end
            if (bus.mem_write_en) begin
                wr_cnt++;
                wr_word = bus.mem_data_in;
                check_eq("wr_addr", 32'(bus.mem_address), 32'(addr & 12'hFFC));
            end
            if (bus.rsp_valid) begin
                got_lat  = n;
                got_data = bus.rsp_rdata;
                got_err  = bus.misalign_err;
                break;
            end
            @(negedge clock);
        end
        check_eq("latency", 32'(got_lat), 32'(exp_lat));
        check_eq("reads", 32'(rd_cnt), 32'(exp_rd));
        check_eq("writes", 32'(wr_cnt), 32'(exp_wr));
        check_eq("rdata", got_data, exp_data);
        check_eq("err", 32'(got_err), 32'(trap));
        check_eq("mfunct3", 32'(bus.mem_funct3), 32'h2);
        if (exp_wr != 0) check_eq("wword", wr_word, exp_word);
        @(negedge clock);
        check_eq("pulse", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int r1, r2;
        logic [31:0] d1, d2, e1, e2;
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        pre_we  = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(1, 32'h8000F0A5);

        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_err", 32'(bus.misalign_err), 32'd0);
        check_eq("rst_rden", 32'(bus.mem_read_en), 32'd0);
        check_eq("rst_wren", 32'(bus.mem_write_en), 32'd0);
        check_eq("rst_wdata", bus.mem_data_in, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // byte/half loads from a known word
        run_req(1'b0, 3'b000, 12'h004, 32'h0);
        run_req(1'b0, 3'b100, 12'h005, 32'h0);
        run_req(1'b0, 3'b001, 12'h006, 32'h0);
        run_req(1'b0, 3'b101, 12'h006, 32'h0);
        check_eq("lb_const", exp_load(3'b000, 12'h004), 32'hFFFFFFA5);
        // word store/load, then read-modify-write lanes
        run_req(1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 12'h010, 32'h0);
        run_req(1'b1, 3'b000, 12'h011, 32'h00000077);
        run_req(1'b1, 3'b001, 12'h012, 32'h00001234);
        run_req(1'b0, 3'b010, 12'h010, 32'h0);
        check_eq("rmw_model", ref_mem[4], 32'h123477EF);

        // req_valid held across two loads
        e1 = exp_load(3'b000, 12'h004);
        e2 = exp_load(3'b010, 12'h010);
        r1 = 0; r2 = 0; d1 = 0; d2 = 0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 12'h004;
        @(posedge clock);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (n == 1) begin bus.req_funct3 = 3'b010; bus.req_addr = 12'h010; end
            if (n == 1 || n == 2) check_eq("b2b_busy", 32'(bus.req_ready), 32'd0);
            if (n == 3) check_eq("b2b_rdy", 32'(bus.req_ready), 32'd1);
            if (n == 4) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                if (r1 == 0) begin r1 = n; d1 = bus.rsp_rdata; end
                else if (r2 == 0) begin r2 = n; d2 = bus.rsp_rdata; end
            end
        end
        check_eq("b2b_r1", 32'(r1), 32'd3);
        check_eq("b2b_r2", 32'(r2), 32'd6);
        check_eq("b2b_d1", d1, e1);
        check_eq("b2b_d2", d2, e2);

        // reset during the write half of an RMW
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 12'h021; bus.req_wdata = 32'h000000AB;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check_eq("rmw_rd", 32'(bus.mem_read_en), 32'd1);
        @(negedge clock);
        check_eq("rmw_wr", 32'(bus.mem_write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_drop_we", 32'(bus.mem_write_en), 32'd0);
        check_eq("rst_drop_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        check_eq("rst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check_eq("post_rst_rdy", 32'(bus.req_ready), 32'd1);
        run_req(1'b0, 3'b010, 12'h020, 32'h0);

        // misaligned word load
        run_req(1'b0, 3'b010, 12'h013, 32'h0);

        for (int i = 0; i < 120; i++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    12'($urandom_range(0, 255)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
